// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: streams X then Y operand words into the multiplier
// RAMs, pulses the multiplier start and waits for its busy handshake.
// Optional watchdog on the busy handshake: define MATRIX_LOAD_TIMEOUT_EN.
module matrix_load_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned X_ROWS         = 2,
    parameter int unsigned Y_COLS         = 2,
    parameter int unsigned X_COLS_Y_ROWS  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [1:0]            ram_sel,
    output logic                  ram_wen,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  mm_start,
    input  logic                  mm_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int unsigned X_WORDS = X_ROWS * X_COLS_Y_ROWS;
    localparam int unsigned Y_WORDS = X_COLS_Y_ROWS * Y_COLS;
    localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(X_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(Y_WORDS - 1);

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_Y = 2'd1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_X    = 3'd1,
        LOAD_Y    = 3'd2,
        START     = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic                    s_ready_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_next;
    logic [1:0]              ram_sel_next;
    logic                    ram_wen_next;
    logic [DATA_WIDTH-1:0]   ram_data_next;
    logic                    mm_start_next;
    logic                    busy_next;
    logic                    done_next;

`ifdef MATRIX_LOAD_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WD_WIDTH-1:0] wd_cnt;
    logic [WD_WIDTH-1:0] wd_cnt_next;
    logic                timeout_err_next;
`else
    // No watchdog: the error flag can never be raised.
    assign timeout_err = 1'b0;
`endif

    // Next-state, word counter and registered-output next values.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        ram_addr_next = ram_addr;
        ram_sel_next  = ram_sel;
        ram_wen_next  = 1'b0;
        ram_data_next = ram_data_in;
        mm_start_next = 1'b0;
`ifdef MATRIX_LOAD_TIMEOUT_EN
        wd_cnt_next      = '0;
        timeout_err_next = timeout_err;
`endif

        case (state)
            IDLE: begin
                if (load) begin
                    state_next = LOAD_X;
                    cnt_next   = '0;
`ifdef MATRIX_LOAD_TIMEOUT_EN
                    timeout_err_next = 1'b0;
`endif
                end
            end
            LOAD_X: begin
                if (s_valid) begin
                    ram_wen_next  = 1'b1;
                    ram_sel_next  = SEL_X;
                    ram_addr_next = cnt;
                    ram_data_next = s_data;
                    if (cnt == X_LAST) begin
                        state_next = LOAD_Y;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            LOAD_Y: begin
                if (s_valid) begin
                    ram_wen_next  = 1'b1;
                    ram_sel_next  = SEL_Y;
                    ram_addr_next = cnt;
                    ram_data_next = s_data;
                    if (cnt == Y_LAST) begin
                        state_next = START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            START: begin
                // START lines up with the last Y write, so the pulse lands one cycle after it.
                mm_start_next = 1'b1;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mm_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!mm_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef MATRIX_LOAD_TIMEOUT_EN
        // Watchdog counts every cycle spent waiting on the multiplier and overrides the FSM on expiry.
        if (state == WAIT_BUSY || state == WAIT_DONE) begin
            wd_cnt_next = wd_cnt + WD_WIDTH'(1);
            if (wd_cnt == WD_LAST) begin
                state_next       = IDLE;
                wd_cnt_next      = '0;
                timeout_err_next = 1'b1;
            end
        end
`endif

        // Status outputs are registered copies of the state being entered.
        s_ready_next = (state_next == LOAD_X) || (state_next == LOAD_Y);
        busy_next    = (state_next != IDLE);
        done_next    = (state_next == DONE);
    end

    // State, counters and all outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            s_ready     <= 1'b0;
            ram_addr    <= '0;
            ram_sel     <= 2'd0;
            ram_wen     <= 1'b0;
            ram_data_in <= '0;
            mm_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef MATRIX_LOAD_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            s_ready     <= s_ready_next;
            ram_addr    <= ram_addr_next;
            ram_sel     <= ram_sel_next;
            ram_wen     <= ram_wen_next;
            ram_data_in <= ram_data_next;
            mm_start    <= mm_start_next;
            busy        <= busy_next;
            done        <= done_next;
`ifdef MATRIX_LOAD_TIMEOUT_EN
            wd_cnt      <= wd_cnt_next;
            timeout_err <= timeout_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// tb_matrix_load_sequencer: table-driven and randomized checks of the load
// sequencer against a write-list reference model built from the operand words.
module tb_matrix_load_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned XR = 2;
    localparam int unsigned YC = 2;
    localparam int unsigned XC = 2;
    localparam int unsigned TO = 1024;
    localparam int unsigned XN = XR * XC;
    localparam int unsigned YN = XC * YC;
    localparam int unsigned NW = XN + YN;
    localparam int unsigned NV = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_sel;
    logic          ram_wen;
    logic [DW-1:0] ram_data_in;
    logic          mm_start;
    logic          mm_busy;
    logic          busy;
    logic          done;
    logic          timeout_err;

    matrix_load_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .X_ROWS(XR), .Y_COLS(YC),
        .X_COLS_Y_ROWS(XC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wen(ram_wen),
        .ram_data_in(ram_data_in), .mm_start(mm_start), .mm_busy(mm_busy),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]             mode;     // 0 back-to-back, 1 alternate gaps, 2 random gaps
        logic                   spam;     // pulse load during LOAD_Y and WAIT_DONE
        logic [3:0]             d;        // mm_busy rise delay after mm_start
        logic [3:0]             h;        // mm_busy high duration
        logic [7:0]             exp_wen;  // expected ram_wen pulses
        logic [7:0]             exp_lag;  // expected cycles from last write to mm_start
        logic [NW-1:0][DW-1:0]  w;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_wen_cyc = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    int  start_q[$];
    int  done_q[$];
    logic [DW-1:0] words [NW];
    vec_t vecs [NV];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RAM write, start pulse and done pulse mid-cycle.
    always @(negedge clk) begin
        if (ram_wen) begin
            obs_q.push_back('{sel: ram_sel, addr: ram_addr, data: ram_data_in});
            last_wen_cyc = cyc;
        end
        if (mm_start) start_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; load is seen on the next edge.
    task automatic pulse_load();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        load = 1'b0; s_valid = 1'b0; mm_busy = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offer words[0..n-1] with the chosen gap pattern until all are accepted.
    task automatic feed(input int n, input int mode, input bit spam, output bit ok);
        int idx = 0;
        int t = 0;
        bit ph = 1'b0;
        bit acc;
        while (idx < n && t < 400) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = ph;
                default: s_valid = ($urandom_range(3) != 0);
            endcase
            ph = !ph;
            s_data = s_valid ? words[idx] : DW'($urandom);
            load = spam && (idx >= int'(XN)) && ($urandom_range(1) == 1);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            t++;
        end
        s_valid = 1'b0;
        load = 1'b0;
        ok = (idx == n);
    endtask

    task automatic wait_start(output int m, output bit ok);
        ok = 1'b0;
        m = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mm_start) begin ok = 1'b1; m = cyc; end
        end
    endtask

    // Expected write list: X row-major into RAM 0, then Y row-major into RAM 1.
    task automatic build_expected();
        exp_q.delete();
        for (int k = 0; k < int'(XN); k++) exp_q.push_back('{sel: 2'd0, addr: AW'(k), data: words[k]});
        for (int k = 0; k < int'(YN); k++) exp_q.push_back('{sel: 2'd1, addr: AW'(k), data: words[int'(XN) + k]});
    endtask

    task automatic run_txn(input vec_t v, input int id);
        bit ok;
        int m;
        int fall;
        int busy_hi;
        @(posedge clk); #1;
        obs_q.delete(); start_q.delete(); done_q.delete();
        for (int k = 0; k < int'(NW); k++) words[k] = v.w[k];
        pulse_load();
        chk($sformatf("v%0d_load_taken", id), 64'({s_ready, busy}), 64'(2'b11));
        feed(int'(NW), int'(v.mode), v.spam, ok);
        chk($sformatf("v%0d_feed_complete", id), 64'(ok), 64'(1));
        wait_start(m, ok);
        chk($sformatf("v%0d_mm_start_seen", id), 64'(ok), 64'(1));
        if (ok) begin
            if (v.d == 0) mm_busy = 1'b1;
            else begin
                repeat (v.d) @(posedge clk);
                #1 mm_busy = 1'b1;
            end
            for (int i = 0; i < int'(v.h); i++) begin
                @(posedge clk); #1;
                load = v.spam && (i == 0) && (v.h > 1);
                if (i == int'(v.h) - 1) mm_busy = 1'b0;
            end
            fall = cyc;
            @(negedge clk);
            chk($sformatf("v%0d_done_at_fall", id), 64'(done), 64'(0));
            @(negedge clk);
            chk($sformatf("v%0d_done_after_fall", id), 64'({done, busy}), 64'(2'b11));
            @(negedge clk);
            chk($sformatf("v%0d_idle_after_done", id), 64'({done, busy}), 64'(2'b00));
            busy_hi = 0;
            repeat (3) begin @(negedge clk); if (busy) busy_hi++; end
            chk($sformatf("v%0d_stays_idle", id), 64'(busy_hi), 64'(0));
            chk($sformatf("v%0d_done_cycle", id), 64'(done_q.size() == 1 ? done_q[0] - fall : -1), 64'(1));
        end
        build_expected();
        chk($sformatf("v%0d_wen_count", id), 64'(obs_q.size()), 64'(v.exp_wen));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("v%0d_write%0d", id, i), 64'(obs_q[i]), 64'(exp_q[i]));
        chk($sformatf("v%0d_start_count", id), 64'(start_q.size()), 64'(1));
        if (start_q.size() > 0)
            chk($sformatf("v%0d_start_lag", id), 64'(start_q[0] - last_wen_cyc), 64'(v.exp_lag));
    endtask

    initial begin
        bit ok;
        int m;
        int low_cnt;

        // Vector table: directed cases first, then randomized ones.
        for (int i = 0; i < int'(NV); i++) begin
            vecs[i].exp_wen = 8'(NW);
            vecs[i].exp_lag = 8'd1;
            vecs[i].spam = 1'b0;
            vecs[i].d = 4'd2;
            vecs[i].h = 4'd10;
            vecs[i].mode = 2'd0;
            for (int k = 0; k < int'(NW); k++) vecs[i].w[k] = DW'(k + 1);
        end
        vecs[1].mode = 2'd1;
        vecs[2].spam = 1'b1; vecs[2].d = 4'd1; vecs[2].h = 4'd4;
        vecs[3].mode = 2'd2; vecs[3].d = 4'd0; vecs[3].h = 4'd1;
        for (int k = 0; k < int'(NW); k++)
            vecs[3].w[k] = (k % 3 == 0) ? 32'hFFFF_FFFF : ((k % 3 == 1) ? 32'h0 : 32'h8000_0001);
        for (int i = 4; i < int'(NV); i++) begin
            vecs[i].mode = 2'd2;
            vecs[i].spam = 1'($urandom_range(1));
            vecs[i].d = 4'($urandom_range(4));
            vecs[i].h = 4'($urandom_range(8, 2));
            for (int k = 0; k < int'(NW); k++) vecs[i].w[k] = DW'($urandom);
        end

        rst = 1'b1; load = 1'b0; s_valid = 1'b0; s_data = '0; mm_busy = 1'b0;
        #2 rst = 1'b0;
        #20;
        chk("reset_outputs",
            64'({s_ready, ram_wen, ram_sel, ram_addr, ram_data_in, mm_start, busy, done, timeout_err}),
            64'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < int'(NV); i++) run_txn(vecs[i], i);

        // Reset after the third X word abandons the sequence.
        @(posedge clk); #1;
        for (int k = 0; k < int'(NW); k++) words[k] = DW'(32'hA0 + k);
        pulse_load();
        feed(3, 0, 1'b0, ok);
        chk("rst_feed3", 64'({ok, ram_wen, ram_addr}), 64'({1'b1, 1'b1, AW'(2)}));
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs",
            64'({s_ready, ram_wen, ram_sel, ram_addr, ram_data_in, mm_start, busy, done, timeout_err}),
            64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        obs_q.delete(); start_q.delete();
        repeat (4) @(negedge clk);
        chk("rst_no_activity", 64'({obs_q.size(), start_q.size()}), 64'(0));
        run_txn(vecs[0], 100);

        // Multiplier never raises busy.
        @(posedge clk); #1;
        for (int k = 0; k < int'(NW); k++) words[k] = DW'($urandom);
        done_q.delete();
        pulse_load();
        feed(int'(NW), 0, 1'b0, ok);
        wait_start(m, ok);
        chk("wd_start_seen", 64'(ok), 64'(1));
`ifdef MATRIX_LOAD_TIMEOUT_EN
        repeat (TO - 1) @(negedge clk);
        chk("wd_busy_last_cycle", 64'({busy, timeout_err}), 64'(2'b10));
        @(negedge clk);
        chk("wd_expired", 64'({busy, timeout_err}), 64'(2'b01));
        chk("wd_no_done", 64'(done_q.size()), 64'(0));
        @(posedge clk); #1;
        pulse_load();
        chk("wd_err_cleared", 64'({busy, timeout_err}), 64'(2'b10));
`else
        low_cnt = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!busy || timeout_err) low_cnt++;
        end
        chk("no_wd_waits", 64'(low_cnt), 64'(0));
        chk("no_wd_no_done", 64'(done_q.size()), 64'(0));
`endif
        do_reset();
        chk("final_idle", 64'({busy, timeout_err}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_load_sequencer.md
MATRIX_LOAD_SEQUENCER -- requirements
Module: matrix_load_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 4 (RAM address width); DATA_WIDTH 32 (word width); X_ROWS 2; Y_COLS 2; X_COLS_Y_ROWS 2; TIMEOUT_CYCLES 1024 (watchdog limit).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 load  in  1  pulse; starts a load/compute sequence when idle.
REQ-005 s_valid  in  1  input word valid.
REQ-006 s_data  in  DATA_WIDTH  input word.
REQ-007 s_ready  out  1  sequencer accepts s_data this cycle.
REQ-008 ram_addr  out  ADDR_WIDTH  multiplier RAM write address.
REQ-009 ram_sel  out  2  target RAM: 0 = X, 1 = Y.
REQ-010 ram_wen  out  1  RAM write enable.
REQ-011 ram_data_in  out  DATA_WIDTH  RAM write data.
REQ-012 mm_start  out  1  one-cycle start pulse to multiplier.
REQ-013 mm_busy  in  1  multiplier busy.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 timeout_err  out  1  sticky watchdog error (REQ-033).

Function
REQ-017 States SHALL be IDLE, LOAD_X, LOAD_Y, START, WAIT_BUSY, WAIT_DONE, DONE.
REQ-018 IDLE->LOAD_X on load=1; load SHALL be ignored in all other states.
REQ-019 s_ready SHALL be 1 only in LOAD_X and LOAD_Y; a word is accepted when s_valid and s_ready are both 1.
REQ-020 LOAD_X SHALL accept X_ROWS*X_COLS_Y_ROWS words, row-major; word k written to ram_sel=0, ram_addr=k.
REQ-021 LOAD_Y SHALL accept X_COLS_Y_ROWS*Y_COLS words, row-major; word k written to ram_sel=1, ram_addr=k.
REQ-022 ram_addr, ram_sel, ram_data_in, ram_wen SHALL be registered; ram_wen high for exactly the one cycle after each accepted word, else 0.
REQ-023 The last X word SHALL move LOAD_X->LOAD_Y with no idle cycle; the last Y word SHALL move to START.
REQ-024 s_valid gaps SHALL stall the word counter without writes; no word dropped or duplicated.
REQ-025 mm_start SHALL be high exactly one cycle, the cycle immediately after the last Y ram_wen cycle.
REQ-026 WAIT_BUSY SHALL hold until mm_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL hold until mm_busy=0, then go to DONE.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE.
REQ-028 Word counters SHALL clear on entry to LOAD_X and LOAD_Y; word counts exceeding 2^ADDR_WIDTH are unsupported configurations.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, counters to 0, and all outputs to 0 (s_ready, ram_*, mm_start, busy, done, timeout_err).
REQ-030 Reset mid-sequence SHALL abandon the sequence; no further ram_wen or mm_start until a new load.
REQ-031 Deassertion SHALL take effect at the next rising clk; first load accepted in the first cycle after.

Configuration
REQ-032 Macro MATRIX_LOAD_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-033 Defined: a counter SHALL count cycles spent in WAIT_BUSY+WAIT_DONE; on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE without done, setting timeout_err until the next accepted load or reset.
REQ-034 Undefined: no counter; WAIT states wait indefinitely; timeout_err tied to 0.

Verification
REQ-035 2x2: load, X words 1,2,3,4 then Y 5,6,7,8 back-to-back -> writes (sel0,addr0..3,data1..4), then (sel1,addr0..3,data5..8); mm_start one cycle after the last write.
REQ-036 Same data, s_valid low every other cycle -> identical write sequence, 8 ram_wen pulses total, no duplicates.
REQ-037 mm_busy model rises 2 cycles after mm_start, falls 10 cycles later -> done high exactly one cycle after mm_busy falls; busy low the following cycle.
REQ-038 rst=0 after 3rd X word -> all outputs 0 immediately; new load rewrites X from addr 0.
REQ-039 mm_busy held 0 after mm_start: with macro, timeout_err=1 and IDLE after 1024 cycles, no done; without macro, busy stays 1 for 2000 cycles.
REQ-040 load pulsed during LOAD_Y and WAIT_DONE -> no state or counter change.
